post_adder_accum: RTL and testbench

POST_ADDER_ACCUM -- requirements
Module: post_adder_accum

---
 rtl/dsp_slice_pkg.sv | 15 +
 rtl/alu_core.sv | 55 +++++
 rtl/post_adder_accum.sv | 123 ++++++++++++
 tb/tb_post_adder_accum.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dsp_slice_pkg.sv
// Shared definitions for the DSP-slice post-adder blocks.
//   DEFAULT_P_WIDTH : default datapath / P register width
//   alumode_e       : post-adder operation select encodings
package dsp_slice_pkg;

  localparam int unsigned DEFAULT_P_WIDTH = 48;

  typedef enum logic [1:0] {
    ALU_ADD     = 2'b00,  // Z' + X + cin
    ALU_NZ_ADD  = 2'b01,  // ~Z' + X + cin
    ALU_NOT_SUM = 2'b10,  // ~(Z' + X + cin)
    ALU_SUB     = 2'b11   // Z' - (X + cin)
  } alumode_e;

endpackage

// File: rtl/alu_core.sv
// Combinational post-adder operation.
// Ports:
//   x, z    : operands (z is the already-selected Z' operand)
//   cin     : carry-in bit
//   alumode : operation select (see dsp_slice_pkg::alumode_e)
//   result  : low P_WIDTH bits of the operation (wraps, no saturation)
//   carry   : carry for add, no-borrow for subtract, 0 otherwise
module alu_core
  import dsp_slice_pkg::*;
#(
  parameter int unsigned P_WIDTH = DEFAULT_P_WIDTH
) (
  input  logic [P_WIDTH-1:0] x,
  input  logic [P_WIDTH-1:0] z,
  input  logic               cin,
  input  logic [1:0]         alumode,
  output logic [P_WIDTH-1:0] result,
  output logic               carry
);

  logic [P_WIDTH:0]   sum_add;
  logic [P_WIDTH:0]   x_cin;
  logic [P_WIDTH:0]   diff;
  logic [P_WIDTH-1:0] sum_nz;

  always_comb begin
    sum_add = {1'b0, z} + {1'b0, x} + {{P_WIDTH{1'b0}}, cin};
    sum_nz  = ~z + x + {{(P_WIDTH-1){1'b0}}, cin};
    x_cin   = {1'b0, x} + {{P_WIDTH{1'b0}}, cin};
    // Top bit of the widened difference is the borrow out.
    diff    = {1'b0, z} - x_cin;
  end

  always_comb begin
    result = '0;
    carry  = 1'b0;
    unique case (alumode)
      ALU_ADD: begin
        result = sum_add[P_WIDTH-1:0];
        carry  = sum_add[P_WIDTH];
      end
      ALU_NZ_ADD: begin
        result = sum_nz;
      end
      ALU_NOT_SUM: begin
        result = ~sum_add[P_WIDTH-1:0];
      end
      ALU_SUB: begin
        result = diff[P_WIDTH-1:0];
        carry  = ~diff[P_WIDTH];
      end
    endcase
  end

endmodule

// File: rtl/post_adder_accum.sv
// Two-stage post-adder / accumulator with optional pattern detect.
// Stage 1 registers the operands; stage 2 computes through alu_core and
// registers the result. With accum=1 the Z operand is replaced by the
// current P register, so back-to-back accumulation uses the previous result.
// Optional feature macro: PATTERN_DETECT_EN (pattern_detect is 0 without it).
// Ports:
//   clk, rst_n     : clock (rising) and synchronous active-low reset
//   ce             : clock enable for every register
//   in_valid       : operands valid this cycle
//   x_in, z_in     : X and Z operands
//   carry_in       : carry-in bit
//   alumode        : operation select
//   accum          : 1 = use P register as Z operand
//   p_out          : registered result
//   carry_out      : registered carry / no-borrow
//   p_valid        : p_out holds a new result
//   pattern_detect : registered masked compare of p_out against PATTERN
module post_adder_accum
  import dsp_slice_pkg::*;
#(
  parameter int unsigned        P_WIDTH = DEFAULT_P_WIDTH,
  parameter logic [P_WIDTH-1:0] PATTERN = '0,
  parameter logic [P_WIDTH-1:0] MASK    = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               in_valid,
  input  logic [P_WIDTH-1:0] x_in,
  input  logic [P_WIDTH-1:0] z_in,
  input  logic               carry_in,
  input  logic [1:0]         alumode,
  input  logic               accum,
  output logic [P_WIDTH-1:0] p_out,
  output logic               carry_out,
  output logic               p_valid,
  output logic               pattern_detect
);

  // Stage 1 registers
  logic [P_WIDTH-1:0] x_q;
  logic [P_WIDTH-1:0] z_q;
  logic               cin_q;
  logic [1:0]         mode_q;
  logic               accum_q;
  logic               valid1_q;

  // Stage 2 registers
  logic [P_WIDTH-1:0] p_q;
  logic               carry_q;
  logic               pvalid_q;

  logic [P_WIDTH-1:0] z_sel;
  logic [P_WIDTH-1:0] alu_result;
  logic               alu_carry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q      <= '0;
      z_q      <= '0;
      cin_q    <= 1'b0;
      mode_q   <= '0;
      accum_q  <= 1'b0;
      valid1_q <= 1'b0;
    end else if (ce) begin
      x_q      <= x_in;
      z_q      <= z_in;
      cin_q    <= carry_in;
      mode_q   <= alumode;
      accum_q  <= accum;
      valid1_q <= in_valid;
    end
  end

  assign z_sel = accum_q ? p_q : z_q;

  alu_core #(
    .P_WIDTH (P_WIDTH)
  ) u_alu_core (
    .x       (x_q),
    .z       (z_sel),
    .cin     (cin_q),
    .alumode (mode_q),
    .result  (alu_result),
    .carry   (alu_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q      <= '0;
      carry_q  <= 1'b0;
      pvalid_q <= 1'b0;
    end else if (ce) begin
      pvalid_q <= valid1_q;
      // Result registers only move on a real operation so idle cycles keep P.
      if (valid1_q) begin
        p_q     <= alu_result;
        carry_q <= alu_carry;
      end
    end
  end

`ifdef PATTERN_DETECT_EN
  logic pdet_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pdet_q <= 1'b0;
    end else if (ce && valid1_q) begin
      pdet_q <= ((alu_result & ~MASK) == (PATTERN & ~MASK));
    end
  end

  assign pattern_detect = pdet_q;
`else
  assign pattern_detect = 1'b0;
`endif

  assign p_out     = p_q;
  assign carry_out = carry_q;
  assign p_valid   = pvalid_q;

endmodule

// File: tb/tb_post_adder_accum.sv
// Randomized self-checking bench for post_adder_accum (default parameters).
// A transaction-level reference model tracks accepted operations and the
// expected P register using plain 64-bit arithmetic.
module tb_post_adder_accum;

  localparam int unsigned W = 48;
  localparam longint unsigned M = 64'h0000_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ce = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] x_in = '0;
  logic [W-1:0] z_in = '0;
  logic         carry_in = 1'b0;
  logic [1:0]   alumode = '0;
  logic         accum = 1'b0;
  logic [W-1:0] p_out;
  logic         carry_out;
  logic         p_valid;
  logic         pattern_detect;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  post_adder_accum dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ce             (ce),
    .in_valid       (in_valid),
    .x_in           (x_in),
    .z_in           (z_in),
    .carry_in       (carry_in),
    .alumode        (alumode),
    .accum          (accum),
    .p_out          (p_out),
    .carry_out      (carry_out),
    .p_valid        (p_valid),
    .pattern_detect (pattern_detect)
  );

  // Reference model: the operation accepted at the last enabled edge, plus outputs.
  typedef struct {
    bit              v;
    longint unsigned x;
    longint unsigned z;
    bit              cin;
    int              mode;
    bit              acc;
  } op_t;

  op_t             pend;
  longint unsigned m_p;
  bit              m_co;
  bit              m_pv;
  bit              m_pd;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_op(input longint unsigned x, input longint unsigned z,
                                 input bit cin, input int mode,
                                 output longint unsigned r, output bit c);
    longint unsigned s;
    c = 1'b0;
    case (mode)
      0: begin s = z + x + cin; r = s & M; c = (s > M); end
      1: begin s = (M - z) + x + cin; r = s & M; end
      2: begin s = (z + x + cin) & M; r = M - s; end
      default: begin s = x + cin; c = (z >= s); r = (z - s) & M; end
    endcase
  endfunction

  task automatic model_clear();
    pend = '{v: 1'b0, x: 0, z: 0, cin: 1'b0, mode: 0, acc: 1'b0};
    m_p = 0; m_co = 1'b0; m_pv = 1'b0; m_pd = 1'b0;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic step(input bit c, input bit v, input longint unsigned x,
                      input longint unsigned z, input bit cin, input int mode, input bit acc);
    longint unsigned r;
    bit              co;
    ce = c; in_valid = v; x_in = x[W-1:0]; z_in = z[W-1:0];
    carry_in = cin; alumode = mode[1:0]; accum = acc;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else if (c) begin
      if (pend.v) begin
        ref_op(pend.x, pend.acc ? m_p : pend.z, pend.cin, pend.mode, r, co);
        m_p = r; m_co = co;
`ifdef PATTERN_DETECT_EN
        m_pd = (r == 0);
`endif
      end
      m_pv = pend.v;
      pend = '{v: v, x: x & M, z: z & M, cin: cin, mode: mode, acc: acc};
    end
    #1;
    check("p_out", p_out, m_p);
    check("carry_out", carry_out, m_co);
    check("p_valid", p_valid, m_pv);
    check("pattern_detect", pattern_detect, m_pd);
  endtask

  task automatic op(input longint unsigned x, input longint unsigned z, input bit cin,
                    input int mode);
    step(1'b1, 1'b1, x, z, cin, mode, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    model_clear();
    // Reset with ce low: must still clear.
    rst_n = 1'b0;
    step(1'b0, 1'b1, 5, 7, 1'b1, 0, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    check("reset_p", p_out, 0);
    rst_n = 1'b1;

    // Add: result on the second enabled edge.
    step(1'b1, 1'b1, 5, 7, 1'b1, 0, 1'b0);
    check("add_lat1", p_valid, 0);
    idle();
    check("add_p", p_out, 13);
    check("add_co", carry_out, 0);
    check("add_pv", p_valid, 1);

    // Wrap-around.
    op(M, 1, 1'b0, 0);
    check("wrap_p", p_out, 0);
    check("wrap_co", carry_out, 1);

    // Subtract with and without borrow.
    op(5, 3, 1'b0, 3);
    check("sub_borrow_p", p_out, 64'hFFFF_FFFF_FFFE);
    check("sub_borrow_co", carry_out, 0);
    op(3, 5, 1'b0, 3);
    check("sub_p", p_out, 2);
    check("sub_co", carry_out, 1);
    op(7, 7, 1'b1, 3);
    op(9, 2, 1'b1, 1);
    op(9, 2, 1'b1, 2);

    // Back-to-back accumulation from a cleared P.
    rst_n = 1'b0; idle(); rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, i, 64'h1234, 1'b0, 0, 1'b1);
    idle();
    check("accum_p", p_out, 10);

    // Stall mid-stream: in-flight op survives 3 disabled cycles.
    step(1'b1, 1'b1, 100, 23, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    check("stall_hold", p_out, 10);
    idle();
    check("stall_p", p_out, 123);

    // Reset mid-stream with ce low.
    step(1'b1, 1'b1, 8, 8, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 1, 1, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    check("rst_mid_p", p_out, 0);
    check("rst_mid_pv", p_valid, 0);
    rst_n = 1'b1;
    idle(); idle();

    // Pattern: 4 + (-4) = 0.
    op(4, M - 3, 1'b0, 0);
    check("pat_p", p_out, 0);
`ifdef PATTERN_DETECT_EN
    check("pat_det", pattern_detect, 1);
`else
    check("pat_det", pattern_detect, 0);
`endif

    // Randomized traffic with stalls, accumulation and occasional resets.
    for (int i = 0; i < 400; i++) begin
      longint unsigned rx;
      longint unsigned rz;
      rx = {$urandom, $urandom};
      rz = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rx = M;
      if ($urandom_range(0, 7) == 0) rz = rx;
      rst_n = ($urandom_range(0, 49) != 0);
      step($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, rx, rz,
           1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2) == 0);
    end
    rst_n = 1'b1;
    idle(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
